// File: rtl/steer_input.sv
// Purpose : turns raw left/right buttons into paced one-cycle move strobes (press, slow repeat, fast repeat).
// Latency : press strobe 2 + DEBOUNCE_CYCLES + 1 clocks after the raw button settles; enable rising while held strobes next clock.
// Backpr. : none; strobes are fire-and-forget single-cycle pulses for the player stage.
//
// Ports:
//   clk        system clock (single domain)
//   reset      synchronous active-high reset
//   btn_left   raw asynchronous bouncing left button
//   btn_right  raw asynchronous bouncing right button
//   enable     1 = game running, 0 = suppress strobes and return to idle
//   left       registered one-cycle move-left strobe
//   right      registered one-cycle move-right strobe
module steer_input #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TICK_DIV        = 250000,
   parameter int REPEAT_SLOW     = 8,
   parameter int REPEAT_FAST     = 2,
   parameter int ACCEL_AFTER     = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_left,
   input  logic btn_right,
   input  logic enable,
   output logic left,
   output logic right
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int RMAX = (REPEAT_SLOW > REPEAT_FAST) ? REPEAT_SLOW : REPEAT_FAST;
   localparam int IW   = $clog2(RMAX + 1);
   localparam int SW   = $clog2(ACCEL_AFTER + 1);

   localparam logic [DW-1:0] DEB_DONE  = DW'(DEBOUNCE_CYCLES);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [IW-1:0] SLOW_LAST = IW'(REPEAT_SLOW - 1);
   localparam logic [IW-1:0] FAST_LAST = IW'(REPEAT_FAST - 1);
   localparam logic [SW-1:0] ACCEL_LAST = SW'(ACCEL_AFTER - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SLOW = 2'd1;
   localparam logic [1:0] FAST = 2'd2;

   // Bit 1 = left button, bit 0 = right button.
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    deb;
   logic [DW-1:0] deb_cnt [2];

   logic [TW-1:0] tick_cnt;
   logic          tick;

   logic [1:0]    state;
   logic          cur_right;
   logic [IW-1:0] ival;
   logic [SW-1:0] step;

   logic          dir_valid;
   logic          dir_right;
   logic          interval_done;

   // Synchronisers and debouncers. A change is accepted only after the
   // synchronised value has disagreed with the debounced value on
   // DEBOUNCE_CYCLES + 1 consecutive clocks; any agreeing clock restarts.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         for (int i = 0; i < 2; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         sync1 <= {btn_left, btn_right};
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_DONE) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
         end
      end
   end

   // Free-running repeat tick; only reset realigns its phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   // Exactly one debounced button gives a direction; none or both is NONE.
   assign dir_valid     = deb[1] ^ deb[0];
   assign dir_right     = deb[0];
   assign interval_done = (state == FAST) ? (ival == FAST_LAST) : (ival == SLOW_LAST);

   // Repeat FSM. A press or direction change is handled before the tick
   // branch, so a coincident tick is dropped rather than counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cur_right <= 1'b0;
         ival      <= '0;
         step      <= '0;
         left      <= 1'b0;
         right     <= 1'b0;
      end else begin
         left  <= 1'b0;
         right <= 1'b0;
         if (!enable) begin
            state <= IDLE;
            ival  <= '0;
            step  <= '0;
         end else begin
            case (state)
               SLOW, FAST: begin
                  if (!dir_valid) begin
                     state <= IDLE;
                     ival  <= '0;
                     step  <= '0;
                  end else if (dir_right != cur_right) begin
                     left      <= ~dir_right;
                     right     <= dir_right;
                     cur_right <= dir_right;
                     ival      <= '0;
                     step      <= '0;
                     state     <= SLOW;
                  end else if (tick) begin
                     if (interval_done) begin
                        left  <= ~cur_right;
                        right <= cur_right;
                        ival  <= '0;
                        // Step count stops advancing once in FAST so it never wraps.
                        if (state == SLOW) begin
                           step <= step + SW'(1);
                           if (step == ACCEL_LAST) begin
                              state <= FAST;
                           end
                        end
                     end else begin
                        ival <= ival + IW'(1);
                     end
                  end
               end
               default: begin
                  if (dir_valid) begin
                     left      <= ~dir_right;
                     right     <= dir_right;
                     cur_right <= dir_right;
                     ival      <= '0;
                     step      <= '0;
                     state     <= SLOW;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_steer_input.sv
module tb_steer_input;

   localparam int D  = 4;
   localparam int TD = 5;
   localparam int RS = 3;
   localparam int RF = 1;
   localparam int AA = 2;

   logic clk       = 1'b0;
   logic reset     = 1'b1;
   logic btn_left  = 1'b0;
   logic btn_right = 1'b0;
   logic enable    = 1'b0;
   logic left;
   logic right;

   steer_input #(
      .DEBOUNCE_CYCLES(D),
      .TICK_DIV(TD),
      .REPEAT_SLOW(RS),
      .REPEAT_FAST(RF),
      .ACCEL_AFTER(AA)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_left(btn_left),
      .btn_right(btn_right),
      .enable(enable),
      .left(left),
      .right(right)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Button path: raw value reaches the debouncer two clocks late; the
   // debounced value flips once the last D+1 delayed samples all disagree.
   // Repeat behaviour: counted ticks since last strobe, slow strobes so far.
   typedef enum int {M_IDLE, M_SLOW, M_FAST} mode_t;

   bit    model_on = 1'b0;
   int    n;
   bit    ql[$];
   bit    qr[$];
   bit    wl[$];
   bit    wr[$];
   bit    debl, debr;
   mode_t mode;
   bit    cur_r;
   int    ticks, slows;
   bit    exp_l, exp_r;

   function automatic bit settled(input bit w[$], input bit d);
      if (w.size() != D + 1) return 1'b0;
      foreach (w[i]) if (w[i] == d) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_press(input bit r);
      exp_l = !r;
      exp_r = r;
      cur_r = r;
      ticks = 0;
      slows = 0;
      mode  = M_SLOW;
   endtask

   task automatic model_step();
      bit s2l, s2r, one_dir, want_r;
      exp_l = 1'b0;
      exp_r = 1'b0;
      if (reset) begin
         n = 0;
         ql = '{1'b0, 1'b0};
         qr = '{1'b0, 1'b0};
         wl.delete();
         wr.delete();
         debl = 1'b0;
         debr = 1'b0;
         mode = M_IDLE;
         cur_r = 1'b0;
         ticks = 0;
         slows = 0;
         model_on = 1'b1;
         return;
      end
      if (!model_on) return;
      n++;
      s2l = ql.pop_front();
      ql.push_back(btn_left);
      s2r = qr.pop_front();
      qr.push_back(btn_right);
      wl.push_back(s2l);
      if (wl.size() > D + 1) void'(wl.pop_front());
      wr.push_back(s2r);
      if (wr.size() > D + 1) void'(wr.pop_front());

      one_dir = (debl != debr);
      want_r  = debr;
      if (!enable) begin
         mode = M_IDLE;
      end else if (mode == M_IDLE) begin
         if (one_dir) model_press(want_r);
      end else if (!one_dir) begin
         mode = M_IDLE;
      end else if (want_r != cur_r) begin
         model_press(want_r);
      end else if (n % TD == 0) begin
         ticks++;
         if (ticks == ((mode == M_FAST) ? RF : RS)) begin
            exp_l = !cur_r;
            exp_r = cur_r;
            ticks = 0;
            if (mode == M_SLOW) begin
               slows++;
               if (slows == AA) mode = M_FAST;
            end
         end
      end

      if (settled(wl, debl)) debl = !debl;
      if (settled(wr, debr)) debr = !debr;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         if (model_on) begin
            check("model_left", left, exp_l);
            check("model_right", right, exp_r);
            check("onehot", left & right, 0);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic do_reset(input bit l, input bit r, input bit en);
      @(negedge clk);
      reset = 1'b1;
      btn_left = l;
      btn_right = r;
      enable = en;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic watch(input int ncyc, output int nl, output int nr,
                        output int first, output bit first_r);
      nl = 0;
      nr = 0;
      first = -1;
      first_r = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         if (left) nl++;
         if (right) nr++;
         if (first < 0 && (left || right)) begin
            first = c;
            first_r = right;
         end
      end
   endtask

   int stl[$];
   int str[$];

   task automatic record(input int ncyc);
      stl.delete();
      str.delete();
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         if (left) stl.push_back(c);
         if (right) str.push_back(c);
      end
   endtask

   typedef struct {
      bit l;
      bit r;
      bit en;
      int exp_first;
      bit exp_r;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int nl, nr, first, total, hold, sel, late_l;
      bit fr;

      vecs[0] = '{1'b1, 1'b0, 1'b1, 7, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 7, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 1'b1, -1, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 1'b1, -1, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 1'b0, -1, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 1'b0, -1, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_left", left, 0);
      check("reset_right", right, 0);

      // Table: constant inputs from edge 0, first strobe time and side
      foreach (vecs[i]) begin
         do_reset(vecs[i].l, vecs[i].r, vecs[i].en);
         watch(30, nl, nr, first, fr);
         check($sformatf("vec%0d_first", i), first, vecs[i].exp_first);
         if (vecs[i].exp_first >= 0) check($sformatf("vec%0d_dir", i), fr, vecs[i].exp_r);
         else check($sformatf("vec%0d_none", i), nl + nr, 0);
      end

      // Bounce rejection
      do_reset(1'b0, 1'b0, 1'b1);
      total = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (c % 2 == 0) btn_left = !btn_left;
         @(posedge clk);
         #1;
         total += int'(left) + int'(right);
      end
      @(negedge clk);
      btn_left = 1'b0;
      watch(20, nl, nr, first, fr);
      check("bounce_during", total, 0);
      check("bounce_after", nl + nr, 0);

      // Press, repeat and acceleration
      do_reset(1'b1, 1'b0, 1'b1);
      record(60);
      check("accel_count_ge5", int'(stl.size() >= 5), 1);
      check("accel_right", str.size(), 0);
      if (stl.size() >= 5) begin
         check("accel_first", stl[0], 7);
         check_range("accel_gap1", stl[1] - stl[0], 11, 15);
         check("accel_gap2", stl[2] - stl[1], 15);
         check("accel_gap3", stl[3] - stl[2], 5);
         check("accel_gap4", stl[4] - stl[3], 5);
      end

      // Direction change from FAST left to right
      @(negedge clk);
      btn_left = 1'b0;
      btn_right = 1'b1;
      record(30);
      check("chg_count_ge2", int'(str.size() >= 2), 1);
      if (str.size() >= 2) begin
         check("chg_first", str[0], 7);
         check_range("chg_gap", str[1] - str[0], 11, 15);
         late_l = 0;
         foreach (stl[i]) if (stl[i] >= str[0]) late_l++;
         check("chg_no_left", late_l, 0);
      end

      // Both pressed, then release right
      do_reset(1'b1, 1'b1, 1'b1);
      watch(50, nl, nr, first, fr);
      check("both_none", nl + nr, 0);
      @(negedge clk);
      btn_right = 1'b0;
      watch(20, nl, nr, first, fr);
      check("both_rel_first", first, 7);
      check("both_rel_dir", fr, 0);

      // Enable gating
      do_reset(1'b0, 1'b1, 1'b0);
      watch(40, nl, nr, first, fr);
      check("en_off_none", nl + nr, 0);
      @(negedge clk);
      enable = 1'b1;
      watch(5, nl, nr, first, fr);
      check("en_on_first", first, 0);
      check("en_on_dir", fr, 1);

      // Reset mid-hold during FAST
      watch(40, nl, nr, first, fr);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_left", left, 0);
      check("rst_mid_right", right, 0);
      @(negedge clk);
      reset = 1'b0;
      record(40);
      check("rst_count_ge2", int'(str.size() >= 2), 1);
      check("rst_no_left", stl.size(), 0);
      if (str.size() >= 2) begin
         check("rst_first", str[0], 7);
         check_range("rst_gap", str[1] - str[0], 11, 15);
      end

      // Randomised stimulus, checked every clock by the model
      hold = 0;
      for (int t = 0; t < 4; t++) begin
         do_reset(1'b0, 1'b0, 1'b1);
         for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            if (hold == 0) begin
               sel = $urandom_range(0, 9);
               btn_left  = (sel < 3) || (sel == 6) || (sel == 7);
               btn_right = (sel >= 3 && sel < 8);
               enable    = ($urandom_range(0, 7) != 0);
               hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(8, 70);
            end
            hold--;
         end
         @(negedge clk);
         reset = 1'b0;
      end

      repeat (3) @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/steer_input.md
# steer_input

Converts the raw left/right steering buttons into paced, single-cycle `left`/`right` move strobes for the player car stage directly downstream. The player stage moves the car one pixel on every clock where exactly one of `left`/`right` is high. This block therefore guarantees a controlled step rate:
- an immediate step on press;
- slow auto-repeat while held;
- fast auto-repeat after a sustained hold.

It sits between the board button pins and the player stage and contains synchronisers, debouncers, a tick divider and a repeat FSM.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable clocks required to accept a button change.
- `TICK_DIV`, default 250000: clocks per repeat tick.
- `REPEAT_SLOW`, default 8: ticks between slow auto-repeat strobes.
- `REPEAT_FAST`, default 2: ticks between fast auto-repeat strobes.
- `ACCEL_AFTER`, default 4: number of slow repeat strobes before switching to fast.

Ports:
- `clk`, input, 1: system clock. Single clock domain.
- `reset`, input, 1: synchronous, active-high.
- `btn_left`, input, 1: raw, asynchronous, bouncing left button.
- `btn_right`, input, 1: raw, asynchronous, bouncing right button.
- `enable`, input, 1: 1 = game running; 0 = suppress all strobes.
- `left`, output, 1: one-cycle move-left strobe.
- `right`, output, 1: one-cycle move-right strobe.

## Operation
- **Synchronise:** each button passes through a 2-flop synchroniser.
- **Debounce:** there is one counter per button. It counts clocks where the synchronised value differs from the debounced value and clears on any clock where they match. When the count reaches `DEBOUNCE_CYCLES`, the debounced value takes the new value and the counter clears.
- **Direction resolve:** left-only gives LEFT, right-only gives RIGHT, and none or both gives NONE.
- **Tick:** a free-running counter runs 0..`TICK_DIV`-1. `tick` is high for one clock when the count equals `TICK_DIV`-1. The counter is cleared only by `reset`.
- **FSM states and transitions:**
  - **IDLE:** on direction ≠ NONE and `enable`=1, strobe that direction, clear the interval and step counters, and go to SLOW.
  - **SLOW:** each `tick` increments the interval counter. When it reaches `REPEAT_SLOW`: strobe, clear the interval counter, and increment the step counter. On the `ACCEL_AFTER`-th such strobe, go to FAST.
  - **FAST:** same as SLOW, but a strobe occurs every `REPEAT_FAST` ticks. Remain in FAST.
  - **In SLOW/FAST:**
    - direction becomes NONE: go to IDLE with no strobe;
    - direction changes to the opposite side: treat as a new press, strobe the new direction immediately, clear the counters, and go to SLOW.
  - **Any state:** `enable`=0 forces IDLE and clears the counters, with no strobe.
- **Priority:** a press or direction-change strobe takes precedence over a coincident `tick`. That tick is not counted.
- **Output invariant:** `left` and `right` are never high together, and each is high for exactly one clock per strobe.
- **Counter widths:** each counter is sized with `$clog2` of its terminal value. No counter may wrap.

## Timing
- **Reset values:** `left`=0, `right`=0, synchronisers=0, debounced=0, all counters=0, state=IDLE. `reset` asserted mid-hold clears all of these on the next edge, so a still-held button must re-debounce fully.
- **Outputs:** `left` and `right` are registered.
- **Press latency:** raw button stable high at edge 0 produces a strobe on cycle 2 + `DEBOUNCE_CYCLES` + 1, provided `enable`=1.
- **Release latency:** a release takes 2 + `DEBOUNCE_CYCLES` clocks to register. No strobe occurs after the debounced release.
- **First repeat:** occurs between (`REPEAT_SLOW`-1)·`TICK_DIV`+1 and `REPEAT_SLOW`·`TICK_DIV` clocks after the press strobe, depending on tick phase.
- **Later repeats:** spaced exactly `REPEAT_SLOW`·`TICK_DIV` clocks apart in SLOW, and `REPEAT_FAST`·`TICK_DIV` in FAST.
- **Enable re-asserted while held:** behaves as a new press, with the strobe on the next clock.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `TICK_DIV`=5, `REPEAT_SLOW`=3, `REPEAT_FAST`=1, `ACCEL_AFTER`=2.

- **Bounce rejection:** `btn_left` toggles every 2 clocks for 30 clocks, then settles at 0 → `left`=`right`=0 throughout.
- **Press, repeat and acceleration:** `btn_left` held from edge 0 with `enable`=1 →
  - `left` pulses on cycle 7;
  - the next two strobes are 11–15 clocks apart, then 15 apart;
  - afterwards strobes are every 5 clocks;
  - `right` stays 0.
- **Direction change:** hold left until it reaches FAST, then switch to right →
  - a `right` strobe occurs 7 clocks after the switch;
  - the next `right` strobe comes 11–15 clocks later (SLOW restarted);
  - no `left` strobe after the switch.
- **Both pressed:** both buttons held for 50 clocks → no strobes. Release `btn_right` → `left` strobe 7 clocks later.
- **Enable gating:** hold right with `enable`=0 for 40 clocks → no strobes. Raise `enable` → `right` strobe on the next clock.
- **Reset mid-hold:** pulse `reset` for 1 clock during FAST while right is held →
  - outputs are 0 on the next clock;
  - the next `right` strobe occurs 7 clocks after `reset` deasserts;
  - SLOW spacing resumes.
